// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned PER_MEM_WORD_DEPTH = 2048;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    wr;
    logic    err;
  } rsp_tag_t;

endpackage

// File: rtl/sram_rsp_tracker.sv
// Delays the response tag of each issued transfer by the SRAM read latency.
module sram_rsp_tracker
  import sram_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic     CLK,
  input  logic     reset,
  input  rsp_tag_t in_tag,
  output rsp_tag_t out_tag
);

  rsp_tag_t stage [READ_LATENCY];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        stage[i] <= rsp_tag_t'('0);
      end
    end else begin
      stage[0] <= in_tag;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[READ_LATENCY-1];

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one banked SRAM port between two requesters.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned NUM_INST     = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_wr,
  input  logic [1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]      req_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]    req_wstrb,
  output logic [1:0]                      rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            CEB,
  output logic                            WEB,
  output logic [DATA_WIDTH-1:0]           BWEB,
  output logic [ADDR_WIDTH-1:0]           A,
  output logic [DATA_WIDTH-1:0]           D,
  input  logic [DATA_WIDTH-1:0]           Q
);

  localparam int unsigned MEM_WORDS = NUM_INST * PER_MEM_WORD_DEPTH;

  req_id_t                   ptr;
  req_id_t                   gnt_id;
  logic                      sel;
  logic                      xfer;
  logic                      sel_wr;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic [DATA_WIDTH/8-1:0]   sel_wstrb;
  logic                      in_range;
  rsp_tag_t                  tag_in;
  rsp_tag_t                  tag_out;

  always_comb begin
    gnt_id    = REQ0;
    req_ready = '0;
    if (!reset && req_valid != 2'b00) begin
      if (req_valid == 2'b11) begin
        gnt_id = ptr;
      end else if (req_valid[1]) begin
        gnt_id = REQ1;
      end else begin
        gnt_id = REQ0;
      end
      req_ready = (gnt_id == REQ1) ? 2'b10 : 2'b01;
    end
  end

  assign xfer      = |req_ready;
  assign sel       = (gnt_id == REQ1);
  assign sel_wr    = req_wr[sel];
  assign sel_addr  = req_addr[sel];
  assign sel_wdata = req_wdata[sel];
  assign sel_wstrb = req_wstrb[sel];
  assign in_range  = 64'(sel_addr) < 64'(MEM_WORDS);

  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
    A    = '0;
    D    = '0;
    if (xfer && in_range) begin
      CEB = 1'b0;
      WEB = ~sel_wr;
      A   = sel_addr;
      D   = sel_wdata;
      if (sel_wr) begin
        for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
          BWEB[b*8 +: 8] = {8{~sel_wstrb[b]}};
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr <= REQ0;
    end else if (xfer) begin
      ptr <= (gnt_id == REQ0) ? REQ1 : REQ0;
    end
  end

  always_comb begin
    tag_in = rsp_tag_t'('0);
    if (xfer) begin
      tag_in.valid = 1'b1;
      tag_in.id    = gnt_id;
      tag_in.wr    = sel_wr;
      tag_in.err   = ~in_range;
    end
  end

  sram_rsp_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tracker (
    .CLK    (CLK),
    .reset  (reset),
    .in_tag (tag_in),
    .out_tag(tag_out)
  );

  // Q is only meaningful for in-range reads; everything else returns zero data.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (tag_out.valid) begin
      rsp_valid = (tag_out.id == REQ1) ? 2'b10 : 2'b01;
      rsp_err   = tag_out.err;
      if (!tag_out.wr && !tag_out.err) begin
        rsp_rdata = Q;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural banked SRAM behind it.
module tb_sram_arbiter;

  localparam int DW = 64;
  localparam int AW = 15;
  localparam int NI = 12;
  localparam int RL = 2;
  localparam int unsigned MEM_WORDS = NI * 2048;

  logic                  CLK = 1'b0;
  logic                  reset = 1'b1;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0]            req_wr = '0;
  logic [1:0][AW-1:0]    req_addr = '0;
  logic [1:0][DW-1:0]    req_wdata = '0;
  logic [1:0][DW/8-1:0]  req_wstrb = '0;
  logic [1:0]            rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic                  CEB, WEB;
  logic [DW-1:0]         BWEB, D, Q;
  logic [AW-1:0]         A;

  always #5 CLK = ~CLK;

  sram_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_INST    (NI),
    .READ_LATENCY(RL)
  ) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D), .Q(Q)
  );

  // Behavioural SRAM driven only by the pins
  logic [DW-1:0] sram [int];
  logic [DW-1:0] q_pipe [RL];
  assign Q = q_pipe[RL-1];

  always @(posedge CLK) begin : sram_model
    logic [DW-1:0] rd;
    logic [DW-1:0] old;
    rd = '0;
    if (!CEB) begin
      old = sram.exists(int'(A)) ? sram[int'(A)] : '0;
      if (!WEB) sram[int'(A)] = (old & BWEB) | (D & ~BWEB);
      else      rd = old;
    end
    q_pipe[0] <= rd;
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
  end

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned  due;
    logic [1:0]   valid;
    logic         err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_mem [int];
  bit            ptr_m = 1'b0;

  always @(negedge CLK) begin : monitor
    exp_t          e;
    bit            g;
    bit            gv;
    logic [AW-1:0] a;
    bit            inr;
    logic [DW-1:0] mask;
    logic [DW-1:0] old;
    if (reset) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
      check("rst_ceb", CEB, 1);
      check("rst_web", WEB, 1);
      check("rst_bweb", BWEB, '1);
      check("rst_a", A, 0);
      check("rst_d", D, 0);
      sbq.delete();
      ptr_m = 1'b0;
    end else begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        check("rsp_valid", rsp_valid, e.valid);
        check("rsp_err", rsp_err, e.err);
        check("rsp_rdata", rsp_rdata, e.data);
      end else begin
        check("rsp_idle_valid", rsp_valid, 0);
        check("rsp_idle_rdata", rsp_rdata, 0);
        check("rsp_idle_err", rsp_err, 0);
      end
      gv = req_valid != 2'b00;
      g  = (req_valid == 2'b11) ? ptr_m : req_valid[1];
      check("ready", req_ready, gv ? (g ? 2'b10 : 2'b01) : 2'b00);
      a   = req_addr[g];
      inr = gv && (int'(a) < int'(MEM_WORDS));
      mask = '0;
      for (int b = 0; b < DW/8; b++) if (req_wstrb[g][b]) mask[b*8 +: 8] = 8'hFF;
      check("ceb", CEB, !inr);
      check("web", WEB, inr ? !req_wr[g] : 1'b1);
      check("bweb", BWEB, (inr && req_wr[g]) ? ~mask : '1);
      check("a", A, inr ? a : '0);
      check("d", D, inr ? req_wdata[g] : '0);
      if (gv) begin
        old = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
        e.due   = cyc + RL;
        e.valid = g ? 2'b10 : 2'b01;
        e.err   = !inr;
        e.data  = (inr && !req_wr[g]) ? old : '0;
        sbq.push_back(e);
        if (inr && req_wr[g]) ref_mem[int'(a)] = (old & ~mask) | (req_wdata[g] & mask);
        ptr_m = !g;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    req_valid[r] = 1'b1;
    req_wr[r]    = wr;
    req_addr[r]  = a;
    req_wdata[r] = d;
    req_wstrb[r] = s;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  logic [1:0]    exp_g [6];
  logic [AW-1:0] pool [7];

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Single write then read on requester 0
    set_req(0, 1'b1, 15'h0005, 64'hDEADBEEF_01234567, 8'hFF);
    @(negedge CLK);
    check("w_ceb", CEB, 0);
    tick();
    set_req(0, 1'b0, 15'h0005, '0, '0);
    @(negedge CLK);
    tick();
    idle();
    @(negedge CLK);
    check("wack_valid", rsp_valid, 2'b01);
    check("wack_rdata", rsp_rdata, 0);
    @(negedge CLK);
    check("rd_valid", rsp_valid, 2'b01);
    check("rd_data", rsp_rdata, 64'hDEADBEEF_01234567);
    check("rd_err", rsp_err, 0);
    tick();

    // Partial write over a preloaded word
    set_req(0, 1'b1, 15'h0800, '1, 8'hFF);
    tick();
    set_req(0, 1'b1, 15'h0800, '0, 8'h0F);
    @(negedge CLK);
    check("pw_bweb", BWEB, 64'hFFFFFFFF_00000000);
    tick();
    set_req(0, 1'b0, 15'h0800, '0, '0);
    tick();
    idle();
    @(negedge CLK);
    @(negedge CLK);
    check("pw_rdata", rsp_rdata, 64'hFFFFFFFF_00000000);
    tick();

    // Out-of-range read on requester 1
    set_req(1, 1'b0, 15'h6000, '0, '0);
    @(negedge CLK);
    check("oor_ceb", CEB, 1);
    tick();
    idle();
    @(negedge CLK);
    @(negedge CLK);
    check("oor_valid", rsp_valid, 2'b10);
    check("oor_err", rsp_err, 1);
    check("oor_rdata", rsp_rdata, 0);
    tick();

    // Random mixed traffic around the range boundary
    pool = '{15'h0005, 15'h0800, 15'h0010, 15'h0020, 15'h5FFF, 15'h6000, 15'h7FFF};
    for (int i = 0; i < 40; i++) begin
      idle();
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 3) != 0)
          set_req(r, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)],
                  {$urandom, $urandom}, 8'($urandom));
      end
      tick();
    end
    idle();
    repeat (RL + 1) tick();

    // Ties straight after reset alternate starting at requester 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b0, 15'h0010, '0, '0);
    set_req(1, 1'b0, 15'h0020, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("tie_gnt", req_ready, exp_g[i]);
      tick();
    end
    idle();
    repeat (RL + 1) tick();

    // Reset while two reads are in flight
    set_req(0, 1'b0, 15'h0005, '0, '0);
    tick();
    idle();
    set_req(1, 1'b0, 15'h0800, '0, '0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("flush_valid", rsp_valid, 0);
    end
    tick();
    set_req(0, 1'b0, 15'h0010, '0, '0);
    set_req(1, 1'b0, 15'h0020, '0, '0);
    @(negedge CLK);
    check("post_rst_tie", req_ready, 2'b01);
    tick();
    idle();
    repeat (RL + 2) tick();

    check("sb_drained", 64'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 64, SRAM word width; ADDR_WIDTH, default 15, word address width; NUM_INST, default 12, number of 2048-word banks; READ_LATENCY, default 2, issue-to-Q cycles of the banked SRAM.
REQ-002 CLK  input  1  clock; reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid  input  [1:0]  per-requester request valid.
REQ-004 req_ready  output  [1:0]  per-requester grant, one-hot or zero.
REQ-005 req_wr  input  [1:0]  per-requester type: 1 = write, 0 = read.
REQ-006 req_addr  input  [1:0][ADDR_WIDTH-1:0]  word address.
REQ-007 req_wdata  input  [1:0][DATA_WIDTH-1:0]  write data.
REQ-008 req_wstrb  input  [1:0][DATA_WIDTH/8-1:0]  active-high byte enables.
REQ-009 rsp_valid  output  [1:0]  per-requester response strobe, one cycle.
REQ-010 rsp_rdata  output  [DATA_WIDTH-1:0]  read data, shared by both requesters.
REQ-011 rsp_err  output  1  out-of-range flag, qualified by rsp_valid.
REQ-012 CEB, WEB  output  1 each  active-low chip enable and write enable to the banked SRAM.
REQ-013 BWEB  output  DATA_WIDTH  active-low bit write mask; A  output  ADDR_WIDTH; D  output  DATA_WIDTH; Q  input  DATA_WIDTH.

Function
REQ-014 A transfer on requester r SHALL occur in a cycle where req_valid[r] and req_ready[r] are both 1; at most one transfer SHALL occur per cycle.
REQ-015 Arbitration SHALL be combinational round-robin: if only one requester is valid, it is granted; if both are valid, the requester indicated by the priority pointer is granted.
REQ-016 After each transfer, the pointer SHALL move to the non-granted requester; with no transfer, the pointer SHALL hold.
REQ-017 req_ready SHALL be 0 when req_valid is 0 and while reset is asserted.
REQ-018 SRAM outputs SHALL be combinational from the granted request, with no added register stage.
- CEB = 0 only for an in-range transfer.
- WEB = ~req_wr.
- A = req_addr; D = req_wdata.
- BWEB bit i = ~req_wstrb[i/8] for writes, all ones for reads.
REQ-019 In a cycle with no in-range transfer, outputs SHALL idle at: CEB = 1, WEB = 1, BWEB = all ones, A = 0, D = 0.
REQ-020 An address >= NUM_INST*2048 SHALL still be accepted, with CEB held at 1 and the transfer marked as an error.
REQ-021 Every transfer issued in cycle N SHALL produce exactly one rsp_valid pulse to the issuing requester in cycle N+READ_LATENCY; writes are acknowledged too.
REQ-022 For an in-range read response, rsp_rdata SHALL equal Q in that cycle and rsp_err SHALL be 0.
REQ-023 For writes and for error responses, rsp_rdata SHALL be 0; for error responses, rsp_err SHALL be 1.
REQ-024 Response tracking SHALL be a READ_LATENCY-deep shift register of {valid, id, wr, err}.
- Back-to-back transfers on every cycle SHALL be sustained.
- No response backpressure exists; requesters always accept responses.
REQ-025 A write and a read to the same address in consecutive cycles SHALL be issued in order; the read returns the written data.
REQ-026 When rsp_valid is 0, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-027 While reset is asserted, the block SHALL hold:
- req_ready = 0 and rsp_valid = 0;
- rsp_rdata = 0 and rsp_err = 0;
- CEB = 1, WEB = 1, BWEB = all ones, A = 0, D = 0;
- the priority pointer at requester 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight responses; none SHALL appear after reset is released.

Structure
REQ-029 Package sram_arb_pkg SHALL hold:
- localparam PER_MEM_WORD_DEPTH = 2048;
- typedef req_id_t (REQ0, REQ1);
- typedef struct rsp_tag_t {valid, id, wr, err}.
REQ-030 The response shift register SHALL be the single sub-module sram_rsp_tracker, parameterized by READ_LATENCY.

Verification
REQ-031 Single write then read, from requester 0:
- stimulus: write addr 0x0005, wdata 0xDEADBEEF_01234567, wstrb 0xFF; then read 0x0005;
- required: write ack at N+2; read rsp_rdata 0xDEADBEEF_01234567 at M+2, rsp_err 0.
REQ-032 Both requesters valid for 6 cycles after reset:
- required grants: 0,1,0,1,0,1;
- required: 6 rsp_valid pulses routed in the same order, each 2 cycles after its grant.
REQ-033 Partial write:
- stimulus: addr 0x0800 preloaded with all ones; write wstrb 0x0F, wdata 0;
- required: BWEB = 0xFFFFFFFF_00000000 on the write; readback 0xFFFFFFFF_00000000.
REQ-034 Out-of-range read of addr 0x6000 with NUM_INST 12:
- required: CEB stays 1 in the issue cycle;
- required: rsp_valid at N+2 with rsp_err 1, rsp_rdata 0.
REQ-035 Reset mid-operation:
- stimulus: issue 2 reads in consecutive cycles, then assert reset for 1 cycle immediately after;
- required: no rsp_valid afterwards; the first post-reset tie is granted to requester 0.
